// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Segment encoding shared by the display driver and the scan-capture receiver.
//   Patterns are active-low, bit [6] = segment a down to bit [0] = segment g.
//   Both ends import these constants so the encode and decode tables cannot drift.
package seg7_pkg;

   localparam int NUM_SEG = 7;

   typedef logic [NUM_SEG-1:0] seg_t;

   localparam seg_t SEG_0     = 7'b0000001;
   localparam seg_t SEG_1     = 7'b1001111;
   localparam seg_t SEG_2     = 7'b0010010;
   localparam seg_t SEG_3     = 7'b0000110;
   localparam seg_t SEG_4     = 7'b1001100;
   localparam seg_t SEG_5     = 7'b0100100;
   localparam seg_t SEG_6     = 7'b0100000;
   localparam seg_t SEG_7     = 7'b0001111;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0000100;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b1100000;
   localparam seg_t SEG_C     = 7'b0110001;
   localparam seg_t SEG_D     = 7'b1000010;
   localparam seg_t SEG_E     = 7'b0110000;
   localparam seg_t SEG_F     = 7'b0111000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   // Encode direction, used by the display driver.
   function automatic seg_t hex_to_seg(input logic [3:0] nibble);
      case (nibble)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational inverse of the segment table.
//   pattern : active-low segment pattern, [6]=a .. [0]=g
//   nibble  : decoded hex value (0 when blank or undecodable)
//   blank   : all segments off
//   err     : pattern is not one of the sixteen digit shapes and not blank
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [NUM_SEG-1:0] pattern,
   output logic [3:0]         nibble,
   output logic               blank,
   output logic               err
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      nibble = 4'h0;
      blank  = 1'b0;
      err    = 1'b0;
      case (pattern)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A:     nibble = 4'hA;
         SEG_B:     nibble = 4'hB;
         SEG_C:     nibble = 4'hC;
         SEG_D:     nibble = 4'hD;
         SEG_E:     nibble = 4'hE;
         SEG_F:     nibble = 4'hF;
         SEG_BLANK: blank  = 1'b1;
         default:   err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Snoops a multiplexed 7-segment bus, filters each lit digit until it is
//   stable, decodes it and assembles complete frames into a parallel value.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   a_to_g, dp  : active-low segments and decimal point
//   an          : active-low anodes, one-cold while a digit is lit
//   value       : last complete frame, digit i at [4i+3:4i]
//   blank_mask  : digit i was dark in the last frame
//   err_mask    : digit i held an undecodable pattern in the last frame
//   dp_mask     : digit i had its decimal point lit in the last frame
//   frame_valid : one-cycle pulse when value and masks update
//   scan_err    : sticky, more than one anode seen low at once
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SEG-1:0]      a_to_g,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic                    dp,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [NUM_DIGITS-1:0]   err_mask,
   output logic [NUM_DIGITS-1:0]   dp_mask,
   output logic                    frame_valid,
   output logic                    scan_err
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(SETTLE_CYCLES - 1);

   logic [NUM_DIGITS-1:0]   an_q, an_p;
   seg_t                    seg_q, seg_p;
   logic                    dp_q, dp_p;
   logic [CNT_W-1:0]        settle_cnt;
   logic [NUM_DIGITS-1:0]   seen;
   logic [4*NUM_DIGITS-1:0] shadow_value;
   logic [NUM_DIGITS-1:0]   shadow_blank, shadow_err, shadow_dp;

   logic                    is_idle, is_lit, is_illegal, changed, capture, frame_done;
   logic [NUM_DIGITS-1:0]   cap_sel;
   logic [3:0]              dec_nibble;
   logic                    dec_blank, dec_err;

   assign is_idle    = &an_q;
   assign is_lit     = $onehot(~an_q);
   assign is_illegal = !is_idle && !is_lit;
   assign changed    = {an_q, seg_q, dp_q} != {an_p, seg_p, dp_p};
   // The count passes CNT_CAPTURE exactly once per stable period because it
   // saturates above it, so capture cannot repeat without a tuple change.
   assign capture    = is_lit && !changed && (settle_cnt == CNT_CAPTURE);
   // The one-cold anode doubles as the one-hot write select.
   assign cap_sel    = capture ? ~an_q : '0;
   assign frame_done = &seen;

   seg7_pattern_decode u_decode (
      .pattern (seg_q),
      .nibble  (dec_nibble),
      .blank   (dec_blank),
      .err     (dec_err)
   );

   // Sampling stage plus a one-sample history for change detection. Idle-high
   // reset values make the first real digit register as a change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q  <= '1;
         seg_q <= '1;
         dp_q  <= 1'b1;
         an_p  <= '1;
         seg_p <= '1;
         dp_p  <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
         an_q  <= an;
         seg_q <= a_to_g;
         dp_q  <= dp;
         an_p  <= an_q;
         seg_p <= seg_q;
         dp_p  <= dp_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         scan_err   <= 1'b0;
      end else begin
         if (changed || !is_lit) begin
            settle_cnt <= '0;
         end else if (settle_cnt != CNT_MAX) begin
            settle_cnt <= settle_cnt + 1'b1;
         end
         if (is_illegal) begin
            scan_err <= 1'b1;
         end
      end
   end

   // Shadow frame. A later capture of the same digit simply overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: shadow storage is reset so a discarded partial frame leaves nothing behind.
         shadow_value <= '0;
         shadow_blank <= '0;
         shadow_err   <= '0;
         shadow_dp    <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
               shadow_value[4*i +: 4] <= dec_nibble;
               shadow_blank[i]        <= dec_blank;
               shadow_err[i]          <= dec_err;
               shadow_dp[i]           <= ~dp_q;
            end
         end
      end
   end

   // Frame publish. A capture landing on the publish edge starts the next
   // frame's seen set; the outputs take the pre-edge shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen        <= '0;
         value       <= '0;
         blank_mask  <= '0;
         err_mask    <= '0;
         dp_mask     <= '0;
         frame_valid <= 1'b0;
      end else if (frame_done) begin
         seen        <= cap_sel;
         value       <= shadow_value;
         blank_mask  <= shadow_blank;
         err_mask    <= shadow_err;
         dp_mask     <= shadow_dp;
         frame_valid <= 1'b1;
      end else begin
         seen        <= seen | cap_sel;
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture
//   Directed scenarios followed by randomized scanning, checked against a
//   frame-level reference model: a digit held long enough is captured, a full
//   set of captured digits publishes a frame at a predicted cycle.
module tb_seg7_scan_capture;

   localparam int ND = 8;
   localparam int S  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    a_to_g;
   logic [ND-1:0] an;
   logic          dp;
   logic [4*ND-1:0] value;
   logic [ND-1:0] blank_mask, err_mask, dp_mask;
   logic          frame_valid, scan_err;

   seg7_scan_capture #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_to_g      (a_to_g),
      .an          (an),
      .dp          (dp),
      .value       (value),
      .blank_mask  (blank_mask),
      .err_mask    (err_mask),
      .dp_mask     (dp_mask),
      .frame_valid (frame_valid),
      .scan_err    (scan_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] ref_tab [16];
   logic [3:0] m_nib [ND];
   logic [ND-1:0] m_blank, m_err, m_dp, m_seen;
   logic [15:0] prev_tuple;
   logic exp_scan_err;

   typedef struct {
      int          at_cyc;
      logic [31:0] val;
      logic [7:0]  blank, err, dpm;
   } frame_t;
   frame_t exp_q[$];

   function automatic logic [7:0] an_of(input int i);
      return ~(8'b1 << i);
   endfunction

   task automatic model_reset();
      m_seen       = '0;
      m_blank      = '0;
      m_err        = '0;
      m_dp         = '0;
      for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
      prev_tuple   = 16'hFFFF;
      exp_scan_err = 1'b0;
   endtask

   // Drive one tuple for 'hold' edges and predict its effect.
   task automatic show(input logic [7:0] an_v, input logic [6:0] seg_v, input logic dp_v, input int hold);
      int zeros;
      int idx;
      int e0;
      logic [3:0] n;
      logic b, e;
      frame_t f;
      zeros = 0;
      idx   = 0;
      an     = an_v;
      a_to_g = seg_v;
      dp     = dp_v;
      e0     = cyc + 1;
      for (int i = 0; i < ND; i++) if (!an_v[i]) begin zeros++; idx = i; end
      if (zeros >= 2) exp_scan_err = 1'b1;
      if (zeros == 1 && hold >= S + 1 && {an_v, seg_v, dp_v} != prev_tuple) begin
         n = 4'h0; b = 1'b0; e = 1'b1;
         if (seg_v == 7'h7F) begin b = 1'b1; e = 1'b0; end
         else for (int k = 0; k < 16; k++) if (ref_tab[k] == seg_v) begin n = 4'(k); e = 1'b0; end
         m_nib[idx]   = n;
         m_blank[idx] = b;
         m_err[idx]   = e;
         m_dp[idx]    = ~dp_v;
         m_seen[idx]  = 1'b1;
         if (&m_seen) begin
            f.at_cyc = e0 + S + 2;
            for (int i = 0; i < ND; i++) f.val[4*i +: 4] = m_nib[i];
            f.blank = m_blank;
            f.err   = m_err;
            f.dpm   = m_dp;
            exp_q.push_back(f);
            m_seen = '0;
         end
      end
      prev_tuple = {an_v, seg_v, dp_v};
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [31:0] v, input int hold);
      for (int i = 0; i < ND; i++) show(an_of(i), ref_tab[v[4*i +: 4]], 1'b1, hold);
   endtask

   // ---------------- frame monitor ----------------
   logic prev_fv = 1'b0;
   int   fv_count = 0;
   always @(negedge clk) begin
      frame_t f;
      if (frame_valid === 1'b1) begin
         fv_count++;
         check("fv_width", 32'(prev_fv), 32'd0);
         check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            check("frame_cycle", cyc, f.at_cyc);
            check("frame_value", value, f.val);
            check("frame_blank", 32'(blank_mask), 32'(f.blank));
            check("frame_err", 32'(err_mask), 32'(f.err));
            check("frame_dp", 32'(dp_mask), 32'(f.dpm));
         end
      end
      prev_fv = frame_valid;
   end

   // ---------------- stimulus ----------------
   initial begin
      int fv0;
      logic [7:0]  r_an;
      logic [6:0]  r_seg;
      logic        r_dp;
      int          a, b2, kind;

      ref_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      model_reset();
      rst_n  = 1'b0;
      an     = '1;
      a_to_g = '1;
      dp     = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_value", value, 32'h0);
      check("rst_masks", {blank_mask, err_mask, dp_mask}, 32'h0);
      check("rst_fv", 32'(frame_valid), 32'd0);
      check("rst_scan_err", 32'(scan_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Plain 1234 frame.
      fv0 = fv_count;
      scan(32'h0000_1234, 16);
      check("t2_pulses", fv_count - fv0, 1);
      check("t2_value", value, 32'h0000_1234);
      check("t2_masks", {blank_mask, err_mask, dp_mask}, 32'h0);

      // Short SEG_7 glitch on digit 2 must be filtered.
      for (int i = 0; i < ND; i++) begin
         if (i == 2) begin
            show(an_of(2), ref_tab[7], 1'b1, S - 1);
            show(an_of(2), ref_tab[5], 1'b1, 16);
         end else begin
            show(an_of(i), ref_tab[i], 1'b1, 16);
         end
      end
      check("t3_value", value, 32'h7654_3510);

      // Blank, undecodable and decimal point.
      show(an_of(0), ref_tab[8], 1'b0, 16);
      for (int i = 1; i < ND; i++) begin
         if (i == 5)      show(an_of(i), 7'b1111111, 1'b1, 16);
         else if (i == 6) show(an_of(i), 7'b1111110, 1'b1, 16);
         else             show(an_of(i), ref_tab[i], 1'b1, 16);
      end
      check("t4_blank", 32'(blank_mask), 32'h20);
      check("t4_err", 32'(err_mask), 32'h40);
      check("t4_dp", 32'(dp_mask), 32'h01);
      check("t4_nibbles56", 32'(value[27:20]), 32'h0);
      check("t4_value", value, 32'h7004_3218);

      // Repeat capture of digit 3 overwrites, then back-to-back frames.
      for (int i = 0; i < 4; i++) show(an_of(i), ref_tab[i == 3 ? 9 : 1], 1'b1, 16);
      show(an_of(4), ref_tab[4], 1'b1, 16);
      show(an_of(3), ref_tab[10], 1'b1, 16);
      for (int i = 5; i < ND; i++) show(an_of(i), ref_tab[i], 1'b1, 16);
      check("t6_digit3", 32'(value[15:12]), 32'hA);
      fv0 = fv_count;
      scan(32'hFEDC_BA98, S + 1);
      scan(32'h0246_8ACE, S + 1);
      repeat (4) @(posedge clk);
      #1;
      check("t6_pulses", fv_count - fv0, 2);
      check("t6_value", value, 32'h0246_8ACE);

      // Illegal anodes: sticky error, no capture, next scan still good.
      check("t5_pre_scan_err", 32'(scan_err), 32'd0);
      show(8'b1111_1100, ref_tab[3], 1'b1, 10);
      check("t5_scan_err", 32'(scan_err), 32'd1);
      scan(32'h1357_9BDF, 16);
      check("t5_value", value, 32'h1357_9BDF);
      check("t5_scan_err_held", 32'(scan_err), 32'd1);

      // Reset mid-frame discards partial frame asynchronously.
      for (int i = 0; i < 4; i++) show(an_of(i), ref_tab[15 - i], 1'b1, 16);
      #3;
      rst_n  = 1'b0;
      an     = '1;
      a_to_g = '1;
      dp     = 1'b1;
      model_reset();
      #1;
      check("t1_value", value, 32'h0);
      check("t1_masks", {blank_mask, err_mask, dp_mask}, 32'h0);
      check("t1_fv", 32'(frame_valid), 32'd0);
      check("t1_scan_err", 32'(scan_err), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fv0 = fv_count;
      for (int i = 4; i < ND; i++) show(an_of(i), ref_tab[i], 1'b1, 16);
      check("t1_no_frame", fv_count - fv0, 0);
      scan(32'h89AB_CDEF, 16);
      check("t1_frames", fv_count - fv0, 1);

      // Randomized scanning.
      for (int step = 0; step < 160; step++) begin
         a     = $urandom_range(0, ND - 1);
         kind  = $urandom_range(0, 11);
         r_an  = an_of(a);
         r_dp  = 1'($urandom_range(0, 1));
         r_seg = ref_tab[$urandom_range(0, 15)];
         if (kind == 0) r_an = 8'hFF;
         else if (kind == 1) begin
            b2   = (a + 1 + $urandom_range(0, ND - 2)) % ND;
            r_an = ~((8'b1 << a) | (8'b1 << b2));
         end
         else if (kind == 2) r_seg = 7'h7F;
         else if (kind == 3) r_seg = 7'($urandom);
         if ({r_an, r_seg, r_dp} == prev_tuple) r_dp = ~r_dp;
         show(r_an, r_seg, r_dp, $urandom_range(2, 10));
      end
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < ND; i++)
            show(an_of(i), ref_tab[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), $urandom_range(S + 1, S + 3));
      end

      an = '1;
      repeat (10) @(posedge clk);
      #1;
      check("pending_frames", exp_q.size(), 0);
      check("final_scan_err", 32'(scan_err), 32'(exp_scan_err));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
